// File: rtl/store_narrow_pkg.sv
// Shared store-path definitions: store_op encodings, byte-enable constants,
// buffer state encodings. Used by the store narrower, load extender, decoder.
package store_narrow_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned OP_W   = 2;

   localparam logic [OP_W-1:0] SOP_NONE = 2'b00;
   localparam logic [OP_W-1:0] SOP_SB   = 2'b01;
   localparam logic [OP_W-1:0] SOP_SH   = 2'b10;
   localparam logic [OP_W-1:0] SOP_SW   = 2'b11;

   localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
   localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
   localparam logic [BE_W-1:0] BE_LO_HALF = 4'b0011;
   localparam logic [BE_W-1:0] BE_HI_HALF = 4'b1100;
   localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

   // Write buffer states: IDLE = empty, FULL = write pending to memory.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_FULL = 1'b1;

endpackage

// File: rtl/store_narrow_lane_gen.sv
// store_lane_gen: combinational byte-lane generator for sb/sh/sw.
// Ports:
//   store_op  - 2-bit store opcode (SOP_*)
//   byte_off  - addr[1:0], byte offset within the word
//   wdata     - full rt register value
//   be        - byte enables, bit i covers lane_data[8i+7:8i]
//   lane_data - data replicated into every lane the op can address
//   misalign  - store violates its natural alignment
module store_lane_gen
   import store_narrow_pkg::*;
(
   input  logic [OP_W-1:0]   store_op,
   input  logic [1:0]        byte_off,
   input  logic [DATA_W-1:0] wdata,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] lane_data,
   output logic              misalign
);

   // Little-endian narrowing; replication lets memory ignore the offset.
   always_comb begin
      be        = BE_NONE;
      lane_data = '0;
      misalign  = 1'b0;
      case (store_op)
         SOP_SB: begin
            be        = BE_W'(BE_BYTE0 << byte_off);
            lane_data = {4{wdata[7:0]}};
         end
         SOP_SH: begin
            be        = byte_off[1] ? BE_HI_HALF : BE_LO_HALF;
            lane_data = {2{wdata[15:0]}};
            misalign  = byte_off[0];
         end
         SOP_SW: begin
            be        = BE_WORD;
            lane_data = wdata;
            misalign  = (byte_off != 2'b00);
         end
         default: begin
            be        = BE_NONE;
            lane_data = '0;
            misalign  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_narrow.sv
// store_narrow: MEM-stage store narrowing with a one-entry valid/ready write
// buffer toward data memory and AdES detection for misaligned stores.
// Ports:
//   clk, reset         - clock (rising edge), async active-high reset
//   req_valid/ready    - pipeline store request handshake
//   store_op, addr     - store type and byte address
//   wdata              - rt register value
//   mem_valid/ready    - memory write handshake
//   mem_addr/be/wdata  - word-aligned address, byte enables, lane data
//   ades, badvaddr     - misaligned-store pulse and faulting address
module store_narrow
   import store_narrow_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   store_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BE_W-1:0]   mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              ades,
   output logic [ADDR_W-1:0] badvaddr
);

   logic [0:0]        state, state_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt, badvaddr_nxt;
   logic [BE_W-1:0]   mem_be_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   logic              ades_nxt;

   logic [BE_W-1:0]   lane_be;
   logic [DATA_W-1:0] lane_data;
   logic              misalign;
   logic              accept, load, reject;

   store_lane_gen u_lane_gen (
      .store_op  (store_op),
      .byte_off  (addr[1:0]),
      .wdata     (wdata),
      .be        (lane_be),
      .lane_data (lane_data),
      .misalign  (misalign)
   );

   // Pass-through ready: a draining buffer can take a new entry the same edge.
   assign req_ready = (state == ST_IDLE) || mem_ready;
   assign accept    = req_valid && req_ready && (store_op != SOP_NONE);
   assign load      = accept && !misalign;
   assign reject    = accept && misalign;
   assign mem_valid = (state == ST_FULL);

   // Next-state and buffer/exception register inputs.
   always_comb begin
      state_nxt     = state;
      mem_addr_nxt  = mem_addr;
      mem_be_nxt    = mem_be;
      mem_wdata_nxt = mem_wdata;
      ades_nxt      = reject;
      badvaddr_nxt  = reject ? addr : badvaddr;

      case (state)
         ST_IDLE: begin
            if (load) begin
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            // Without mem_ready, req_ready is low so nothing is loaded: hold.
            if (mem_ready && !load) begin
               state_nxt  = ST_IDLE;
               mem_be_nxt = BE_NONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (load) begin
         mem_addr_nxt  = {addr[ADDR_W-1:2], 2'b00};
         mem_be_nxt    = lane_be;
         mem_wdata_nxt = lane_data;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         mem_addr  <= '0;
         mem_be    <= BE_NONE;
         mem_wdata <= '0;
         ades      <= 1'b0;
         badvaddr  <= '0;
      end else begin
         state     <= state_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_be    <= mem_be_nxt;
         mem_wdata <= mem_wdata_nxt;
         ades      <= ades_nxt;
         badvaddr  <= badvaddr_nxt;
      end
   end

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow: directed scenarios plus random
// traffic, compared against a transaction-level reference model.
module tb_store_narrow;

   localparam int unsigned ADDR_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        store_op;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              ades;
   logic [ADDR_W-1:0] badvaddr;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic        m_v;
   logic [31:0] m_addr, m_data, m_bad;
   logic [3:0]  m_be;
   logic        m_ades;

   store_narrow #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .store_op  (store_op),
      .addr      (addr),
      .wdata     (wdata),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .ades      (ades),
      .badvaddr  (badvaddr)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_v = 1'b0; m_addr = '0; m_data = '0; m_be = '0; m_ades = 1'b0; m_bad = '0;
   endtask

   task automatic check_outputs();
      check_eq("mem_valid", 32'(mem_valid), 32'(m_v));
      check_eq("mem_addr",  mem_addr, m_addr);
      check_eq("mem_be",    32'(mem_be), 32'(m_be));
      check_eq("mem_wdata", mem_wdata, m_data);
      check_eq("ades",      32'(ades), 32'(m_ades));
      check_eq("badvaddr",  badvaddr, m_bad);
   endtask

   // One cycle: apply inputs, check ready, advance model and DUT, check outputs.
   task automatic step(input logic rv, input logic [1:0] op, input logic [31:0] ad,
                       input logic [31:0] wd, input logic mr);
      int size, off;
      logic mis, rdy, acc;
      logic [3:0]  be;
      logic [31:0] data;
      req_valid = rv; store_op = op; addr = ad; wdata = wd; mem_ready = mr;
      #1;
      rdy = !m_v || mr;
      check_eq("req_ready", 32'(req_ready), 32'(rdy));

      size = (op == 2'd1) ? 1 : (op == 2'd2) ? 2 : 4;
      off  = int'(ad % 4);
      mis  = (off % size) != 0;
      be   = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) data[8*i +: 8] = wd[8*(i % size) +: 8];
      acc  = rv && rdy && (op != 2'd0);

      @(posedge clk); #1;
      m_ades = acc && mis;
      if (acc && mis) m_bad = ad;
      if (acc && !mis) begin
         m_v = 1'b1; m_addr = {ad[31:2], 2'b00}; m_be = be; m_data = data;
      end else if (m_v && mr) begin
         m_v = 1'b0; m_be = 4'b0000;
      end
      check_outputs();
   endtask

   task automatic idle_cycle(input logic mr);
      step(1'b0, 2'd0, 32'h0, 32'h0, mr);
   endtask

   initial begin
      req_valid = 0; store_op = 0; addr = 0; wdata = 0; mem_ready = 1;
      reset = 1'b1;
      model_reset();
      #12;
      check_outputs();
      reset = 1'b0;
      @(posedge clk); #1;

      // sb at 0x13: top lane
      step(1'b1, 2'd1, 32'h13, 32'hAABBCCDD, 1'b1);
      check_eq("sb_be_const", 32'(mem_be), 32'h8);
      check_eq("sb_data_const", mem_wdata, 32'hDDDDDDDD);
      idle_cycle(1'b1);
      check_eq("sb_drained", 32'(mem_valid), 32'h0);

      // aligned sh and sw
      step(1'b1, 2'd2, 32'h22, 32'h1234BEEF, 1'b1);
      check_eq("sh_data_const", mem_wdata, 32'hBEEFBEEF);
      step(1'b1, 2'd3, 32'h40, 32'hCAFEF00D, 1'b1);
      check_eq("sw_be_const", 32'(mem_be), 32'hF);
      idle_cycle(1'b1);

      // misaligned sh / sw: single-cycle ades
      step(1'b1, 2'd2, 32'h31, 32'h11112222, 1'b1);
      check_eq("ades_sh_const", 32'(ades), 32'h1);
      idle_cycle(1'b1);
      check_eq("ades_pulse_end", 32'(ades), 32'h0);
      step(1'b1, 2'd3, 32'h42, 32'h33334444, 1'b1);
      check_eq("bad_sw_const", badvaddr, 32'h42);
      idle_cycle(1'b1);

      // back-pressure: buffer held 3 cycles, then sb loads on drain edge
      step(1'b1, 2'd3, 32'h40, 32'hCAFEF00D, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 32'h05, 32'h000000A5, 1'b0);
      check_eq("bp_held_data", mem_wdata, 32'hCAFEF00D);
      step(1'b1, 2'd1, 32'h05, 32'h000000A5, 1'b1);
      check_eq("bp_sb_be", 32'(mem_be), 32'h2);
      check_eq("bp_sb_addr", mem_addr, 32'h04);
      idle_cycle(1'b1);

      // misaligned accept while draining: both happen
      step(1'b1, 2'd3, 32'h80, 32'h01020304, 1'b0);
      step(1'b1, 2'd3, 32'h81, 32'h05060708, 1'b1);
      idle_cycle(1'b1);

      // streaming four sw
      for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 32'(32'h100 + 4*i), 32'(i * 32'h01010101), 1'b1);
      idle_cycle(1'b1);

      // no-op with valid is consumed silently
      step(1'b1, 2'd0, 32'h13, 32'hFFFFFFFF, 1'b1);

      // async reset mid-FULL
      step(1'b1, 2'd3, 32'h200, 32'hDEADBEEF, 1'b0);
      req_valid = 1'b0; mem_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_eq("rst_async_valid", 32'(mem_valid), 32'h0);
      check_eq("rst_async_be", 32'(mem_be), 32'h0);
      check_eq("rst_async_ades", 32'(ades), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_cycle(1'b1);
      idle_cycle(1'b0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         logic rv, mr;
         logic [1:0]  op;
         logic [31:0] ad, wd;
         rv = ($urandom_range(0, 3) != 0);
         mr = ($urandom_range(0, 9) < 7);
         op = 2'($urandom_range(0, 3));
         ad = 32'($urandom_range(0, 1023));
         wd = $urandom;
         step(rv, op, ad, wd, mr);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
